// File: rtl/pim_indirect_readback.sv
// Pipelined MMIO read responder for the PIM indirect-addressing args A/B/C and per-bank LUT-x buffers.
// Optional per-response error flag for unmapped reads: define PIM_RDBK_ERR_RESP_EN.
`timescale 1ns/1ps

module pim_indirect_readback #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_x,
    input  logic              i_rd_en,
    input  logic [31:0]       i_rd_addr,
    output logic              o_rd_ready,
    output logic              o_rd_valid,
    output logic [255:0]      o_rd_data,
    input  logic              i_rd_resp_ready,
    input  logic [31:0]       i_args_reg_A,
    input  logic [31:0]       i_args_reg_B,
    input  logic [31:0]       i_args_reg_C,
    input  logic [255:0]      i_args_reg_LUT_x [15:0],
    input  logic              i_HPC_clear,
    output logic [CNT_W-1:0]  o_rd_cnt
`ifdef PIM_RDBK_ERR_RESP_EN
    ,
    output logic              o_rd_err
`endif
);

    localparam int unsigned DATA_W = 256;
    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned OCC_W  = $clog2(FIFO_DEPTH + 1) + 1;

    logic              s1_valid;
    logic              s1_valid_nxt;
    logic [31:0]       s1_addr;
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [OCC_W-1:0]  fifo_count;
    logic [OCC_W-1:0]  count_nxt;
    logic              rd_ready_q;
    logic              ready_nxt;
    logic [CNT_W-1:0]  rd_cnt_q;
    logic              accept;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] src_data;
`ifdef PIM_RDBK_ERR_RESP_EN
    logic              src_err;
    logic [FIFO_DEPTH-1:0] fifo_err;
`endif

    // Clear overrides every same-cycle accept, push and pop.
    assign accept       = i_rd_en && rd_ready_q && !i_HPC_clear;
    assign push         = s1_valid && !i_HPC_clear;
    assign pop          = (fifo_count != '0) && i_rd_resp_ready && !i_HPC_clear;
    assign s1_valid_nxt = accept;

    // Stage-1 decode: exact matches for args, 512-byte window for the LUT banks.
    always_comb begin
        src_data = '0;
`ifdef PIM_RDBK_ERR_RESP_EN
        src_err  = 1'b1;
`endif
        if (s1_addr == 32'h0000_1000) begin
            src_data = DATA_W'(i_args_reg_A);
`ifdef PIM_RDBK_ERR_RESP_EN
            src_err  = 1'b0;
`endif
        end else if (s1_addr == 32'h0000_2000) begin
            src_data = DATA_W'(i_args_reg_B);
`ifdef PIM_RDBK_ERR_RESP_EN
            src_err  = 1'b0;
`endif
        end else if (s1_addr == 32'h0000_3000) begin
            src_data = DATA_W'(i_args_reg_C);
`ifdef PIM_RDBK_ERR_RESP_EN
            src_err  = 1'b0;
`endif
        end else if (s1_addr[31:9] == 23'h40) begin
            src_data = i_args_reg_LUT_x[s1_addr[8:5]];
`ifdef PIM_RDBK_ERR_RESP_EN
            src_err  = 1'b0;
`endif
        end
    end

    always_comb begin
        count_nxt = fifo_count;
        if (i_HPC_clear) begin
            count_nxt = '0;
        end else if (push && !pop) begin
            count_nxt = fifo_count + OCC_W'(1);
        end else if (pop && !push) begin
            count_nxt = fifo_count - OCC_W'(1);
        end
    end

    // Credits: stored entries plus the request sitting in stage 1.
    assign ready_nxt = (count_nxt + OCC_W'(s1_valid_nxt)) < OCC_W'(FIFO_DEPTH);

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            s1_valid   <= 1'b0;
            s1_addr    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            rd_ready_q <= 1'b1;
            rd_cnt_q   <= '0;
        end else begin
            s1_valid   <= s1_valid_nxt;
            fifo_count <= count_nxt;
            rd_ready_q <= ready_nxt;
            if (accept) begin
                s1_addr <= i_rd_addr;
            end
            if (i_HPC_clear) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                rd_cnt_q <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr   <= rd_ptr + PTR_W'(1);
                    rd_cnt_q <= rd_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // Storage needs no reset: entries are only visible while counted as occupied.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= src_data;
`ifdef PIM_RDBK_ERR_RESP_EN
            fifo_err[wr_ptr]  <= src_err;
`endif
        end
    end

    assign o_rd_ready = rd_ready_q;
    assign o_rd_valid = (fifo_count != '0);
    assign o_rd_data  = o_rd_valid ? fifo_data[rd_ptr] : '0;
    assign o_rd_cnt   = rd_cnt_q;
`ifdef PIM_RDBK_ERR_RESP_EN
    assign o_rd_err   = o_rd_valid && fifo_err[rd_ptr];
`endif

endmodule

// File: tb/tb_pim_indirect_readback.sv
// Bench for pim_indirect_readback: directed cases plus random traffic against a transaction-level model.
`timescale 1ns/1ps

module tb_pim_indirect_readback;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 4;

    logic           clk = 1'b0;
    logic           rst_x;
    logic           i_rd_en;
    logic [31:0]    i_rd_addr;
    logic           o_rd_ready;
    logic           o_rd_valid;
    logic [255:0]   o_rd_data;
    logic           i_rd_resp_ready;
    logic [31:0]    a_reg, b_reg, c_reg;
    logic [255:0]   lut [15:0];
    logic           i_HPC_clear;
    logic [CW-1:0]  o_rd_cnt;
`ifdef PIM_RDBK_ERR_RESP_EN
    logic           o_rd_err;
`endif

    pim_indirect_readback #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk             (clk),
        .rst_x           (rst_x),
        .i_rd_en         (i_rd_en),
        .i_rd_addr       (i_rd_addr),
        .o_rd_ready      (o_rd_ready),
        .o_rd_valid      (o_rd_valid),
        .o_rd_data       (o_rd_data),
        .i_rd_resp_ready (i_rd_resp_ready),
        .i_args_reg_A    (a_reg),
        .i_args_reg_B    (b_reg),
        .i_args_reg_C    (c_reg),
        .i_args_reg_LUT_x(lut),
        .i_HPC_clear     (i_HPC_clear),
        .o_rd_cnt        (o_rd_cnt)
`ifdef PIM_RDBK_ERR_RESP_EN
        ,
        .o_rd_err        (o_rd_err)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference state: queued responses, request waiting for its data sample, credit flag, pop count.
    logic [255:0]   exp_d[$];
    logic           exp_e[$];
    logic           m_pend;
    logic [31:0]    m_addr;
    logic           m_ready;
    logic [CW-1:0]  m_cnt;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic is_mapped(input logic [31:0] addr);
        return (addr == 32'h1000) || (addr == 32'h2000) || (addr == 32'h3000) ||
               (addr >= 32'h8000 && addr <= 32'h81FF);
    endfunction

    function automatic logic [255:0] ref_data(input logic [31:0] addr);
        logic [255:0] r = '0;
        if (addr == 32'h1000)      r[31:0] = a_reg;
        else if (addr == 32'h2000) r[31:0] = b_reg;
        else if (addr == 32'h3000) r[31:0] = c_reg;
        else if (addr >= 32'h8000 && addr <= 32'h81FF) r = lut[(addr - 32'h8000) / 32];
        return r;
    endfunction

    task automatic model_reset();
        exp_d.delete();
        exp_e.delete();
        m_pend  = 1'b0;
        m_addr  = '0;
        m_ready = 1'b1;
        m_cnt   = '0;
    endtask

    // Applies the effect of the clock edge that just passed, using the inputs held across it.
    task automatic model_step();
        logic acc;
        if (i_HPC_clear) begin
            model_reset();
            return;
        end
        acc = i_rd_en && m_ready;
        if (exp_d.size() != 0 && i_rd_resp_ready) begin
            void'(exp_d.pop_front());
            void'(exp_e.pop_front());
            m_cnt = m_cnt + 1'b1;
        end
        if (m_pend) begin
            exp_d.push_back(ref_data(m_addr));
            exp_e.push_back(!is_mapped(m_addr));
        end
        m_pend  = acc;
        m_addr  = i_rd_addr;
        m_ready = (exp_d.size() + (m_pend ? 1 : 0)) < DEPTH;
    endtask

    task automatic check_outputs();
        logic has = (exp_d.size() != 0);
        chk("valid", o_rd_valid, has);
        chk("data", o_rd_data, has ? exp_d[0] : 256'b0);
        chk("ready", o_rd_ready, m_ready);
        chk("cnt", o_rd_cnt, m_cnt);
`ifdef PIM_RDBK_ERR_RESP_EN
        chk("err", o_rd_err, has ? exp_e[0] : 1'b0);
`endif
    endtask

    task automatic cycle(input logic en, input logic [31:0] addr, input logic rr, input logic clr);
        @(negedge clk);
        model_step();
        check_outputs();
        i_rd_en         = en;
        i_rd_addr       = addr;
        i_rd_resp_ready = rr;
        i_HPC_clear     = clr;
    endtask

    task automatic idle(input int n, input logic rr);
        for (int k = 0; k < n; k++) cycle(1'b0, 32'h0, rr, 1'b0);
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 5))
            0: return 32'h1000;
            1: return 32'h2000;
            2: return 32'h3000;
            3: return 32'h8000 + $urandom_range(0, 511);
            4: return 32'h1000 + $urandom_range(1, 3) * 4;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int acc_cnt;
        logic [255:0] pat;
        rst_x = 1'b0;
        i_rd_en = 1'b0; i_rd_addr = '0; i_rd_resp_ready = 1'b0; i_HPC_clear = 1'b0;
        a_reg = 32'h1111_2222; b_reg = 32'hDEAD_BEEF; c_reg = 32'h3333_4444;
        for (int k = 0; k < 16; k++) lut[k] = '0;
        model_reset();

        @(posedge clk); #1;
        chk("rst_valid", o_rd_valid, 1'b0);
        chk("rst_data", o_rd_data, 256'b0);
        chk("rst_ready", o_rd_ready, 1'b1);
        chk("rst_cnt", o_rd_cnt, '0);
        @(negedge clk);
        rst_x = 1'b1;

        // Read B, response at N+2, one pop counted.
        cycle(1'b1, 32'h2000, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        chk("b_n1_valid", o_rd_valid, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        chk("b_n2_valid", o_rd_valid, 1'b1);
        chk("b_n2_data", o_rd_data, {224'b0, 32'hDEAD_BEEF});
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        chk("b_cnt", o_rd_cnt, 4'd1);

        // LUT bank 13, low address bits ignored.
        pat = {32{8'hA5}};
        lut[13] = pat;
        cycle(1'b1, 32'h81A0, 1'b1, 1'b0);
        cycle(1'b1, 32'h81BF, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        chk("lut_a0", o_rd_data, pat);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        chk("lut_bf", o_rd_data, pat);
        idle(2, 1'b1);

        // Unmapped address returns zero.
        cycle(1'b1, 32'h1004, 1'b1, 1'b0);
        idle(1, 1'b1);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        chk("unmapped_valid", o_rd_valid, 1'b1);
        chk("unmapped_data", o_rd_data, 256'b0);
`ifdef PIM_RDBK_ERR_RESP_EN
        chk("unmapped_err", o_rd_err, 1'b1);
`endif
        idle(2, 1'b1);

        // Back-pressure: only DEPTH requests accepted, then one pop frees one credit.
        acc_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            cycle(1'b1, (k < 3) ? 32'h1000 * (k + 1) : 32'h8000 + 32 * k, 1'b0, 1'b0);
            if (o_rd_ready) acc_cnt++;
        end
        chk("full_accepts", acc_cnt, DEPTH);
        idle(2, 1'b0);
        chk("full_ready", o_rd_ready, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        chk("credit_ready", o_rd_ready, 1'b1);
        idle(6, 1'b1);

        // Clear with a same-cycle request and pop.
        cycle(1'b1, 32'h1000, 1'b0, 1'b0);
        cycle(1'b1, 32'h2000, 1'b0, 1'b0);
        cycle(1'b1, 32'h3000, 1'b0, 1'b0);
        idle(2, 1'b0);
        cycle(1'b1, 32'h1000, 1'b1, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        chk("clr_valid", o_rd_valid, 1'b0);
        chk("clr_cnt", o_rd_cnt, '0);
        chk("clr_ready", o_rd_ready, 1'b1);
        idle(4, 1'b1);

        // Asynchronous reset during stage 1 of a read.
        cycle(1'b1, 32'h1000, 1'b1, 1'b0);
        @(posedge clk); #2;
        rst_x = 1'b0;
        i_rd_en = 1'b0;
        #1;
        chk("arst_valid", o_rd_valid, 1'b0);
        chk("arst_data", o_rd_data, 256'b0);
        chk("arst_ready", o_rd_ready, 1'b1);
        chk("arst_cnt", o_rd_cnt, '0);
        model_reset();
        @(negedge clk);
        rst_x = 1'b1;
        a_reg = 32'h0BAD_F00D;
        idle(2, 1'b1);
        cycle(1'b1, 32'h1000, 1'b1, 1'b0);
        idle(1, 1'b1);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        chk("arst_fresh_a", o_rd_data, {224'b0, 32'h0BAD_F00D});
        idle(2, 1'b1);

        // Random traffic with changing sources and occasional clears.
        for (int k = 0; k < 16; k++) lut[k] = rand256();
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) a_reg = $urandom;
            if ($urandom_range(0, 3) == 0) b_reg = $urandom;
            if ($urandom_range(0, 3) == 0) c_reg = $urandom;
            if ($urandom_range(0, 3) == 0) lut[$urandom_range(0, 15)] = rand256();
            cycle($urandom_range(0, 2) != 0, rand_addr(), $urandom_range(0, 2) != 0,
                  $urandom_range(0, 39) == 0);
        end
        idle(8, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
